rx_to_mem: RTL

Upstream loader for the matrix multiplier's UART path. Consumes bytes delivered by the UART receiver, synchronises its ready strobe into the system clock domain, and writes the bytes row-major into matrix memories A and B through their write ports. Pulses `load_done` once both matrices are full so the multiply stage can start. This is the write-side counterpart of the memory-to-transmitter stage.

---
 rtl/rx_to_mem.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/rx_to_mem.sv
// -----------------------------------------------------------------------------
// rx_to_mem
//
// Loader between the UART receiver and the matrix memories. Each byte flagged
// by the receiver's ready level is synchronised into the clk domain and
// written row-major into matrix A (first ROW*COLUMN bytes) and then matrix B
// (next ROW*COLUMN bytes). A one-cycle load_done pulse marks a complete
// A+B frame so the multiply stage can start.
//
// Optional feature (compile-time macro RX_TIMEOUT_EN):
//   defined     - an inter-byte timeout of TIMEOUT_CYCLES clk cycles in LOAD
//                 aborts the frame and pulses load_error.
//   not defined - no timeout counter exists, load_error is tied to 0 and the
//                 loader waits indefinitely for the next byte.
//
// Parameters:
//   ROW, COLUMN     matrix dimensions (A and B share them)
//   ADDR_W          memory address width, ROW*COLUMN <= 2**ADDR_W
//   TIMEOUT_CYCLES  inter-byte timeout in clk cycles (RX_TIMEOUT_EN only)
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-low reset
//   rx_status      receiver byte-ready level (foreign clock domain)
//   rx_byte        received byte, stable while rx_status is high
//   frame_clear    synchronous abort of the current frame
//   write_A/_B     one-cycle write strobes to memory A / memory B
//   write_address  element address inside the selected matrix
//   write_value    byte being written
//   load_done      one-cycle pulse, both matrices loaded
//   load_error     one-cycle pulse on timeout abort
//   busy           frame in progress
//   state_LED      one-hot FSM state (IDLE 1000, LOAD 0100, WRITE 0010,
//                  DONE 0001); doubles as the FSM debug view
//
// Handshake: rx_status is a level, not a valid/ready pair. Each rising edge
// of the synchronised level delivers exactly one byte; there is no
// backpressure toward the receiver, so a byte arriving while the FSM is busy
// (WRITE or DONE) is parked in a one-deep holding register instead.
// -----------------------------------------------------------------------------
module rx_to_mem #(
    parameter int ROW            = 2,
    parameter int COLUMN         = 2,
    parameter int ADDR_W         = 6,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_status,
    input  logic [7:0]        rx_byte,
    input  logic              frame_clear,
    output logic              write_A,
    output logic              write_B,
    output logic [ADDR_W-1:0] write_address,
    output logic [7:0]        write_value,
    output logic              load_done,
    output logic              load_error,
    output logic              busy,
    output logic [3:0]        state_LED
);

    localparam int N     = ROW * COLUMN;
    localparam int IDX_W = (2 * N > 1) ? $clog2(2 * N) : 1;

    // Elaboration-time sanity checks on the parameter set.
    if (N > 2 ** ADDR_W) begin : g_bad_addr_w
        $error("rx_to_mem: ROW*COLUMN does not fit in ADDR_W");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("rx_to_mem: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [3:0] {
        IDLE  = 4'b1000,
        LOAD  = 4'b0100,
        WRITE = 4'b0010,
        DONE  = 4'b0001
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;

    // Two-flop synchroniser plus a third flop for edge detection. edge_q
    // registers the detected rising edge so the FSM sees a clean one-cycle
    // pulse; a level held high therefore produces exactly one byte.
    logic sync1, sync2, sync3, edge_q;

    // One-deep parking slot for a byte that lands while WRITE/DONE is busy.
    logic       pending;
    logic [7:0] hold;

    logic              take;
    logic [7:0]        take_byte;
    logic              is_a;
    logic              is_last;
    logic [ADDR_W-1:0] addr_sel;

    always_comb begin
        take      = edge_q | pending;
        // A parked byte is older than a fresh edge, so it goes first.
        take_byte = pending ? hold : rx_byte;
        is_a      = (idx < IDX_W'(N));
        is_last   = (idx == IDX_W'(2 * N - 1));
        addr_sel  = is_a ? ADDR_W'(idx) : ADDR_W'(idx - IDX_W'(N));
    end

    assign state_LED = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync3  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync1  <= rx_status;
            sync2  <= sync1;
            sync3  <= sync2;
            edge_q <= sync2 & ~sync3;
        end
    end

`ifdef RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign load_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            idx           <= '0;
            pending       <= 1'b0;
            hold          <= 8'h00;
            write_A       <= 1'b0;
            write_B       <= 1'b0;
            write_address <= '0;
            write_value   <= 8'h00;
            load_done     <= 1'b0;
            busy          <= 1'b0;
`ifdef RX_TIMEOUT_EN
            load_error    <= 1'b0;
            tmo_cnt       <= '0;
`endif
        end else begin
            // Strobes and pulses are single-cycle by default.
            write_A   <= 1'b0;
            write_B   <= 1'b0;
            load_done <= 1'b0;
`ifdef RX_TIMEOUT_EN
            load_error <= 1'b0;
`endif
            if (frame_clear) begin
                // Abort wins over everything, including a same-cycle edge.
                state   <= IDLE;
                idx     <= '0;
                pending <= 1'b0;
                busy    <= 1'b0;
`ifdef RX_TIMEOUT_EN
                tmo_cnt <= '0;
`endif
            end else begin
                case (state)
                    IDLE, LOAD: begin
                        if (take) begin
                            state         <= WRITE;
                            busy          <= 1'b1;
                            write_A       <= is_a;
                            write_B       <= ~is_a;
                            write_address <= addr_sel;
                            write_value   <= take_byte;
                            // If a fresh edge coincides with consuming the
                            // parked byte, the fresh one takes its place.
                            if (pending && edge_q) begin
                                pending <= 1'b1;
                                hold    <= rx_byte;
                            end else begin
                                pending <= 1'b0;
                            end
`ifdef RX_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end
`ifdef RX_TIMEOUT_EN
                        else if (state == LOAD) begin
                            if (tmo_hit) begin
                                load_error <= 1'b1;
                                state      <= IDLE;
                                idx        <= '0;
                                busy       <= 1'b0;
                                tmo_cnt    <= '0;
                            end else begin
                                tmo_cnt <= tmo_cnt + 1'b1;
                            end
                        end
`endif
                    end

                    WRITE: begin
                        if (edge_q) begin
                            pending <= 1'b1;
                            hold    <= rx_byte;
                        end
                        idx <= idx + 1'b1;
                        if (is_last) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state <= LOAD;
                        end
                    end

                    DONE: begin
                        if (edge_q) begin
                            pending <= 1'b1;
                            hold    <= rx_byte;
                        end
                        idx   <= '0;
                        state <= IDLE;
                    end

                    default: begin
                        state <= IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
